msrv32_alu_arbiter: RTL and testbench

//  Shares one msrv32_alu instance between NUM_REQ requesters (e.g. EX stage, address-gen, CSR unit).

---
 rtl/msrv32_alu_arbiter.sv | 162 ++++++++++++++++
 tb/tb_msrv32_alu_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_alu_arbiter.sv
// rtl/msrv32_alu_arbiter.sv - shares one combinational msrv32_alu between NUM_REQ requesters
// Define MSRV32_ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module msrv32_alu_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic                    ms_riscv32_mp_clk_in,
    input  logic                    ms_riscv32_mp_rst_in,
    input  logic [NUM_REQ-1:0]      req_valid_in,
    output logic [NUM_REQ-1:0]      req_ready_out,
    input  logic [NUM_REQ*32-1:0]   req_op1_in,
    input  logic [NUM_REQ*32-1:0]   req_op2_in,
    input  logic [NUM_REQ*4-1:0]    req_opcode_in,
    output logic [31:0]             alu_op_1_out,
    output logic [31:0]             alu_op_2_out,
    output logic [3:0]              alu_opcode_out,
    input  logic [31:0]             alu_result_in,
    output logic                    resp_valid_out,
    input  logic                    resp_ready_in,
    output logic [ID_W-1:0]         resp_id_out,
    output logic [31:0]             resp_result_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [ID_W-1:0]     w_grant;
    logic                w_any_valid;
    logic                w_handshake;
    logic [31:0]         w_sel_op1;
    logic [31:0]         w_sel_op2;
    logic [3:0]          w_sel_opcode;
    logic [31:0]         r_alu_op_1;
    logic [31:0]         r_alu_op_2;
    logic [3:0]          r_alu_opcode;
    logic [ID_W-1:0]     r_resp_id;
    logic [31:0]         r_resp_result;

    assign w_any_valid = |req_valid_in;
    assign w_handshake = (r_state == S_IDLE) && w_any_valid;

`ifdef MSRV32_ALU_ARB_FIXED_PRIO_EN
    // Descending scan: the last hit, i.e. the lowest valid index, wins.
    always_comb begin
        w_grant = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_in[i]) begin
                w_grant = ID_W'(i);
            end
        end
    end
`else
    logic [ID_W-1:0]     r_last_grant;
    logic                w_hi_found;

    // Lowest valid index above last_grant wins; otherwise wrap to the lowest valid overall.
    always_comb begin
        w_grant    = '0;
        w_hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid_in[i] && (ID_W'(i) > r_last_grant)) begin
                w_grant    = ID_W'(i);
                w_hi_found = 1'b1;
            end
        end
        if (!w_hi_found) begin
            for (int i = NUM_REQ - 1; i >= 0; i--) begin
                if (req_valid_in[i]) begin
                    w_grant = ID_W'(i);
                end
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_last_grant <= ID_W'(NUM_REQ - 1);
        end else if (w_handshake) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    always_comb begin
        w_sel_op1    = '0;
        w_sel_op2    = '0;
        w_sel_opcode = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant == ID_W'(i)) begin
                w_sel_op1    = req_op1_in[32*i +: 32];
                w_sel_op2    = req_op2_in[32*i +: 32];
                w_sel_opcode = req_opcode_in[4*i +: 4];
            end
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (w_any_valid) w_next_state = S_EXEC;
            S_EXEC:  w_next_state = S_RESP;
            S_RESP:  if (resp_ready_in) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // Ready is masked by reset so nothing is offered while the block is held in reset.
    always_comb begin
        req_ready_out  = '0;
        resp_valid_out = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_valid && !ms_riscv32_mp_rst_in) begin
                    req_ready_out = NUM_REQ'(1) << w_grant;
                end
            end
            S_RESP:  resp_valid_out = 1'b1;
            default: ;
        endcase
    end

    // Operands stay on the ALU after completion; result is sampled in the single EXEC cycle.
    always_ff @(posedge ms_riscv32_mp_clk_in or posedge ms_riscv32_mp_rst_in) begin
        if (ms_riscv32_mp_rst_in) begin
            r_alu_op_1    <= '0;
            r_alu_op_2    <= '0;
            r_alu_opcode  <= '0;
            r_resp_id     <= '0;
            r_resp_result <= '0;
        end else begin
            if (w_handshake) begin
                r_alu_op_1   <= w_sel_op1;
                r_alu_op_2   <= w_sel_op2;
                r_alu_opcode <= w_sel_opcode;
                r_resp_id    <= w_grant;
            end
            if (r_state == S_EXEC) begin
                r_resp_result <= alu_result_in;
            end
        end
    end

    assign alu_op_1_out    = r_alu_op_1;
    assign alu_op_2_out    = r_alu_op_2;
    assign alu_opcode_out  = r_alu_opcode;
    assign resp_id_out     = r_resp_id;
    assign resp_result_out = r_resp_result;

endmodule

// File: tb/tb_msrv32_alu_arbiter.sv
// tb/tb_msrv32_alu_arbiter.sv - scoreboard bench for msrv32_alu_arbiter with a stub ALU
module tb_msrv32_alu_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_op1;
    logic [63:0] req_op2;
    logic [7:0]  req_opcode;
    logic [31:0] alu_op_1;
    logic [31:0] alu_op_2;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_result;
    logic        resp_valid;
    logic        resp_ready;
    logic [0:0]  resp_id;
    logic [31:0] resp_result;

    typedef struct packed {
        logic [0:0]  id;
        logic [31:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   gid;
    int   gcyc;
    int   prev_cyc;
    int   start_cyc;
    int   t3_order[4];

    msrv32_alu_arbiter #(.NUM_REQ(2), .ID_W(1)) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst),
        .req_valid_in         (req_valid),
        .req_ready_out        (req_ready),
        .req_op1_in           (req_op1),
        .req_op2_in           (req_op2),
        .req_opcode_in        (req_opcode),
        .alu_op_1_out         (alu_op_1),
        .alu_op_2_out         (alu_op_2),
        .alu_opcode_out       (alu_opcode),
        .alu_result_in        (alu_result),
        .resp_valid_out       (resp_valid),
        .resp_ready_in        (resp_ready),
        .resp_id_out          (resp_id),
        .resp_result_out      (resp_result)
    );

    // Stub ALU: ADD, SUB, otherwise XOR.
    always_comb begin
        case (alu_opcode)
            4'b0000: alu_result = alu_op_1 + alu_op_2;
            4'b1000: alu_result = alu_op_1 - alu_op_2;
            default: alu_result = alu_op_1 ^ alu_op_2;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual id=%0d result=%h required=none", resp_id, resp_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_resp_id", 64'(resp_id), 64'(e.id));
                chk("sb_resp_result", 64'(resp_result), 64'(e.res));
            end
        end
    end

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        req_valid[i]          = v;
        req_op1[32*i +: 32]   = a;
        req_op2[32*i +: 32]   = b;
        req_opcode[4*i +: 4]  = op;
    endtask

    task automatic push_exp(input logic [0:0] id, input logic [31:0] res);
        exp_t e;
        e.id  = id;
        e.res = res;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(output int g, output int gc);
        g  = -1;
        gc = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if ((req_ready & req_valid) != 2'b00) begin
                g  = req_ready[1] ? 1 : 0;
                gc = cyc;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout actual=no ready required=ready within 30 cycles");
    endtask

    task automatic drain();
        for (int t = 0; t < 30; t++) begin
            if (exp_q.size() == 0) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef MSRV32_ALU_ARB_FIXED_PRIO_EN
        t3_order = '{0, 0, 0, 0};
`else
        t3_order = '{0, 1, 0, 1};
`endif
        rst        = 1'b1;
        resp_ready = 1'b1;
        req_valid  = 2'b11;
        req_op1    = '0;
        req_op2    = '0;
        req_opcode = '0;
        #12;
        chk("rst_resp", 64'({resp_valid, resp_id, resp_result}), 64'd0);
        chk("rst_alu", {alu_op_1, alu_op_2}, 64'd0);
        chk("rst_ctl", 64'({alu_opcode, req_ready}), 64'd0);
        req_valid = 2'b00;
        @(posedge clk); #1;
        rst = 1'b0;

        // Test 1: req0 add
        @(posedge clk); #1;
        start_cyc = cyc;
        set_req(0, 1'b1, 32'd5, 32'd7, 4'b0000);
        wait_grant(gid, gcyc);
        chk("t1_grant", 64'(gid), 64'd0);
        chk("t1_ready_same_cycle", 64'(gcyc), 64'(start_cyc));
        push_exp(1'b0, 32'd12);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        chk("t1_exec_no_valid", 64'(resp_valid), 64'd0);
        chk("t1_alu_ops", {alu_op_1, alu_op_2}, {32'd5, 32'd7});
        @(negedge clk);
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        drain();

        // Test 2: req1 sub
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'd3, 32'd5, 4'b1000);
        wait_grant(gid, gcyc);
        chk("t2_grant", 64'(gid), 64'd1);
        push_exp(1'b1, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
        drain();

        // Test 3: both held valid
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'd10, 32'd20, 4'b0000);
        set_req(1, 1'b1, 32'd100, 32'd1, 4'b1000);
        prev_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            wait_grant(gid, gcyc);
            chk("t3_order", 64'(gid), 64'(t3_order[k]));
            if (k > 0) chk("t3_spacing", 64'(gcyc - prev_cyc), 64'd3);
            prev_cyc = gcyc;
            push_exp((t3_order[k] != 0) ? 1'b1 : 1'b0, (t3_order[k] != 0) ? 32'd99 : 32'd30);
            @(posedge clk); #1;
        end
        set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
        drain();

        // Test 4: response backpressure with req1 waiting
        @(posedge clk); #1;
        resp_ready = 1'b0;
        set_req(0, 1'b1, 32'h1234_5678, 32'h1111_1111, 4'b0000);
        set_req(1, 1'b1, 32'd7, 32'd2, 4'b1000);
        wait_grant(gid, gcyc);
        chk("t4_grant", 64'(gid), 64'd0);
        push_exp(1'b0, 32'h2345_6789);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("t4_hold", 64'({resp_valid, resp_id, resp_result}), 64'({1'b1, 1'b0, 32'h2345_6789}));
            chk("t4_no_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1;
        resp_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        chk("t4_done", 64'(resp_valid), 64'd0);
        wait_grant(gid, gcyc);
        chk("t4_next_grant", 64'(gid), 64'd1);
        push_exp(1'b1, 32'd5);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
        drain();

        // Test 5: reset during EXEC
        @(posedge clk); #1;
        set_req(0, 1'b1, 32'd9, 32'd4, 4'b0000);
        wait_grant(gid, gcyc);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_resp_zero", 64'({resp_valid, resp_id, resp_result}), 64'd0);
        chk("t5_alu_zero", {alu_op_1, alu_op_2}, 64'd0);
        chk("t5_ctl_zero", 64'({alu_opcode, req_ready}), 64'd0);
        for (int n = 0; n < 2; n++) begin
            @(negedge clk);
            chk("t5_no_resp_in_rst", 64'(resp_valid), 64'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_no_resp_after_rst", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        set_req(1, 1'b1, 32'd50, 32'd8, 4'b1000);
        wait_grant(gid, gcyc);
        chk("t5_grant", 64'(gid), 64'd1);
        push_exp(1'b1, 32'd42);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 4'b0000);
        drain();

        repeat (3) @(posedge clk);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
